// File: rtl/capture_pkg.sv
// Shared state encoding and default widths for the capture controller.
package capture_pkg;

  localparam int unsigned DefDataW  = 10;
  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefDecimW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } capture_state_e;

endpackage

// File: rtl/capture_decimator.sv
// Count-down tick generator: ticks on the first active edge after a load, then every
// ratio+1 active edges. Only instantiated when CAPTURE_DECIM_EN is defined.
module capture_decimator
  import capture_pkg::*;
#(
  parameter int unsigned DECIM_W = DefDecimW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [DECIM_W-1:0] i_ratio,
  input  logic               i_active,
  output logic               o_tick
);

  logic [DECIM_W-1:0] r_ratio;
  logic [DECIM_W-1:0] r_cnt;

  assign o_tick = i_active && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ratio <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      // Zero count makes the very first capture edge a write.
      r_ratio <= i_ratio;
      r_cnt   <= '0;
    end else if (i_active) begin
      if (r_cnt == '0) begin
        r_cnt <= r_ratio;
      end else begin
        r_cnt <= r_cnt - DECIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Writes a programmed number of ADC samples into the sample FIFO after a start request.
// Optional decimation is enabled by defining CAPTURE_DECIM_EN.
module capture_controller
  import capture_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned DECIM_W = DefDecimW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               capture_go_i,
  input  logic [DATA_W-1:0]  adc_data_i,
  input  logic [CNT_W-1:0]   max_samples_i,
  input  logic [DECIM_W-1:0] decim_i,
  input  logic               fifo_full_i,
  output logic               fifo_wr_en_o,
  output logic [DATA_W-1:0]  fifo_data_o,
  output logic               capture_done_o,
  output logic               overflow_o,
  output logic [CNT_W-1:0]   sample_count_o
);

  capture_state_e    r_state, w_state_next;
  logic [CNT_W-1:0]  r_max, w_max_next;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic [CNT_W-1:0]  w_count_inc;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_wr_en, w_wr_en_next;
  logic              r_done, w_done_next;
  logic              r_ovf, w_ovf_next;
  logic              w_start;
  logic              w_in_capture;
  logic              w_write_due;

  assign w_start      = (r_state == StIdle) && capture_go_i;
  assign w_in_capture = (r_state == StCapture);
  assign w_count_inc  = r_count + CNT_W'(1);

`ifdef CAPTURE_DECIM_EN
  capture_decimator #(
    .DECIM_W(DECIM_W)
  ) u_decim (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_start),
    .i_ratio (decim_i),
    .i_active(w_in_capture),
    .o_tick  (w_write_due)
  );
`else
  logic w_unused_decim;
  assign w_unused_decim = ^decim_i;
  assign w_write_due    = w_in_capture;
`endif

  always_comb begin
    w_state_next = r_state;
    w_max_next   = r_max;
    w_count_next = r_count;
    w_data_next  = r_data;
    w_wr_en_next = 1'b0;
    w_done_next  = r_done;
    w_ovf_next   = r_ovf;

    unique case (r_state)
      StIdle: begin
        w_done_next = 1'b0;
        if (capture_go_i) begin
          w_max_next   = max_samples_i;
          w_count_next = '0;
          w_ovf_next   = 1'b0;
          w_state_next = (max_samples_i == '0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (w_write_due) begin
          if (fifo_full_i) begin
            w_ovf_next   = 1'b1;
            w_state_next = StDone;
          end else begin
            w_wr_en_next = 1'b1;
            w_data_next  = adc_data_i;
            w_count_next = w_count_inc;
            if (w_count_inc == r_max) begin
              w_state_next = StDone;
            end
          end
        end
      end
      StDone: begin
        // Done is always shown for at least one cycle before go can release it.
        if (!r_done) begin
          w_done_next = 1'b1;
        end else if (!capture_go_i) begin
          w_done_next  = 1'b0;
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_max   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_max   <= w_max_next;
      r_count <= w_count_next;
      r_data  <= w_data_next;
      r_wr_en <= w_wr_en_next;
      r_done  <= w_done_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign fifo_wr_en_o   = r_wr_en;
  assign fifo_data_o    = r_data;
  assign capture_done_o = r_done;
  assign overflow_o     = r_ovf;
  assign sample_count_o = r_count;

endmodule
